y86_seq_controller: RTL and testbench

Multi-cycle sequencer for the Y86-64 SEQ processor. Owns the program counter, steps the six SEQ stages one per clock with single-cycle enable pulses, selects the next PC from fetch/execute/memory results, and maintains the architectural status code. Sits above `fetch_seq` and the decode/execute/memory/writeback blocks as the only writer of `p_ctr`.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_next_pc.sv | 23 ++
 rtl/y86_seq_controller.sv | 189 ++++++++++++++++++
 tb/tb_y86_seq_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, architectural status codes and
// the SEQ sequencer state encoding.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'd0;
   localparam logic [3:0] I_NOP    = 4'd1;
   localparam logic [3:0] I_RRMOVQ = 4'd2;
   localparam logic [3:0] I_IRMOVQ = 4'd3;
   localparam logic [3:0] I_RMMOVQ = 4'd4;
   localparam logic [3:0] I_MRMOVQ = 4'd5;
   localparam logic [3:0] I_OPQ    = 4'd6;
   localparam logic [3:0] I_JXX    = 4'd7;
   localparam logic [3:0] I_CALL   = 4'd8;
   localparam logic [3:0] I_RET    = 4'd9;
   localparam logic [3:0] I_PUSHQ  = 4'd10;
   localparam logic [3:0] I_POPQ   = 4'd11;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 4'd4;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PC_UPDATE = 3'd6,
      S_STOP      = 3'd7
   } seq_state_e;

endpackage

// File: rtl/y86_next_pc.sv
// Combinational next-PC select: branch/call target, return address, or the
// sequential successor.
module y86_next_pc
   import y86_pkg::*;
(
   input  logic [3:0]  icode_i,
   input  logic        cnd_i,
   input  logic [63:0] val_c_i,
   input  logic [63:0] val_p_i,
   input  logic [63:0] val_m_i,
   output logic [63:0] next_pc_o
);

   always_comb begin
      next_pc_o = val_p_i;
      if (icode_i == I_CALL || (icode_i == I_JXX && cnd_i)) begin
         next_pc_o = val_c_i;
      end else if (icode_i == I_RET) begin
         next_pc_o = val_m_i;
      end
   end

endmodule

// File: rtl/y86_seq_controller.sv
// Y86-64 SEQ sequencer: owns the PC, strobes one stage per clock, tracks stat.
// Optional SEQ_PERF_COUNTERS_EN adds saturating cycle_cnt / instr_cnt outputs.
module y86_seq_controller
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter int          MEM_BYTES = 1024
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  in_code,
   input  logic [63:0] val_c,
   input  logic [63:0] val_p,
   input  logic        flag_halt,
   input  logic        bad_mem,
   input  logic        in_error,
   input  logic        cnd,
   input  logic [63:0] val_m,
   input  logic        dmem_error,
   output logic [63:0] p_ctr,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        execute_en,
   output logic        memory_en,
   output logic        writeback_en,
   output logic [2:0]  stat,
   output logic        busy,
   output logic        done
`ifdef SEQ_PERF_COUNTERS_EN
   ,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instr_cnt
`endif
);

   localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

   seq_state_e  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [2:0]  stat_q, stat_d;
   logic [3:0]  icode_q, icode_d;
   logic [63:0] valc_q, valc_d;
   logic [63:0] valp_q, valp_d;
   logic [63:0] valm_q, valm_d;
   logic        cnd_q, cnd_d;
   logic [63:0] next_pc;

   y86_next_pc u_next_pc (
      .icode_i   (icode_q),
      .cnd_i     (cnd_q),
      .val_c_i   (valc_q),
      .val_p_i   (valp_q),
      .val_m_i   (valm_q),
      .next_pc_o (next_pc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         stat_q  <= STAT_AOK;
         icode_q <= 4'd0;
         valc_q  <= 64'd0;
         valp_q  <= 64'd0;
         valm_q  <= 64'd0;
         cnd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stat_q  <= stat_d;
         icode_q <= icode_d;
         valc_q  <= valc_d;
         valp_q  <= valp_d;
         valm_q  <= valm_d;
         cnd_q   <= cnd_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      stat_d       = stat_q;
      icode_d      = icode_q;
      valc_d       = valc_q;
      valp_d       = valp_q;
      valm_d       = valm_q;
      cnd_d        = cnd_q;
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      execute_en   = 1'b0;
      memory_en    = 1'b0;
      writeback_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            // An out-of-range PC faults before fetch is ever strobed.
            if (pc_q >= MEM_LIMIT) begin
               state_d = S_STOP;
               stat_d  = STAT_ADR;
            end else begin
               fetch_en = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (bad_mem) begin
               state_d = S_STOP;
               stat_d  = STAT_ADR;
            end else if (in_error) begin
               state_d = S_STOP;
               stat_d  = STAT_INS;
            end else if (flag_halt) begin
               state_d = S_STOP;
               stat_d  = STAT_HLT;
            end else begin
               decode_en = 1'b1;
               icode_d   = in_code;
               valc_d    = val_c;
               valp_d    = val_p;
               state_d   = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            execute_en = 1'b1;
            cnd_d      = cnd;
            state_d    = S_MEMORY;
         end
         S_MEMORY: begin
            memory_en = 1'b1;
            if (dmem_error) begin
               state_d = S_STOP;
               stat_d  = STAT_ADR;
            end else begin
               valm_d  = val_m;
               state_d = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            writeback_en = 1'b1;
            state_d      = S_PC_UPDATE;
         end
         S_PC_UPDATE: begin
            pc_d    = next_pc;
            state_d = S_FETCH;
         end
         S_STOP: begin
            state_d = S_STOP;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign p_ctr = pc_q;
   assign stat  = stat_q;
   assign busy  = (state_q != S_IDLE) && (state_q != S_STOP);
   assign done  = (state_q == S_STOP);

`ifdef SEQ_PERF_COUNTERS_EN
   logic [63:0] cycle_cnt_q, cycle_cnt_d;
   logic [63:0] instr_cnt_q, instr_cnt_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt_q <= 64'd0;
         instr_cnt_q <= 64'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (busy && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + 64'd1;
      if ((state_q == S_PC_UPDATE) && (instr_cnt_q != '1)) instr_cnt_d = instr_cnt_q + 64'd1;
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_y86_seq_controller.sv
// Bench for y86_seq_controller: a program table feeds an emulated fetch stage,
// and a per-instruction trace model predicts every cycle's outputs.
module tb_y86_seq_controller;

   typedef struct packed {
      logic [3:0]  icode;
      logic [63:0] vc;
      logic [63:0] vp;
      logic [63:0] vm;
      logic        halt;
      logic        bad;
      logic        ierr;
      logic        cnd;
      logic        derr;
   } ins_t;

   typedef struct packed {
      logic [4:0]  strb;
      logic [63:0] pc;
      logic [2:0]  stat;
      logic        busy;
      logic        done;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] p_ctr;
   logic        fetch_en, decode_en, execute_en, memory_en, writeback_en;
   logic [2:0]  stat;
   logic        busy, done;
`ifdef SEQ_PERF_COUNTERS_EN
   logic [63:0] cycle_cnt, instr_cnt;
`endif

   ins_t        prog [logic [63:0]];
   ins_t        cur = '0;
   exp_t        exp_q [$];
   bit          chk_en = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;

   always #5 clock = ~clock;

   y86_seq_controller #(.RESET_PC(64'd0), .MEM_BYTES(1024)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .in_code      (cur.icode),
      .val_c        (cur.vc),
      .val_p        (cur.vp),
      .flag_halt    (cur.halt),
      .bad_mem      (cur.bad),
      .in_error     (cur.ierr),
      .cnd          (cur.cnd),
      .val_m        (cur.vm),
      .dmem_error   (cur.derr),
      .p_ctr        (p_ctr),
      .fetch_en     (fetch_en),
      .decode_en    (decode_en),
      .execute_en   (execute_en),
      .memory_en    (memory_en),
      .writeback_en (writeback_en),
      .stat         (stat),
      .busy         (busy),
      .done         (done)
`ifdef SEQ_PERF_COUNTERS_EN
      ,
      .cycle_cnt    (cycle_cnt),
      .instr_cnt    (instr_cnt)
`endif
   );

   function automatic ins_t mk(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                               input logic [63:0] vm, input logic h, input logic b, input logic ie,
                               input logic c, input logic de);
      ins_t r;
      r.icode = ic; r.vc = vc; r.vp = vp; r.vm = vm;
      r.halt = h; r.bad = b; r.ierr = ie; r.cnd = c; r.derr = de;
      return r;
   endfunction

   function automatic ins_t lookup(input logic [63:0] a);
      if (prog.exists(a)) return prog[a];
      return mk(4'd0, 64'd0, a + 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   // Emulated fetch/execute/memory outputs, registered on the FETCH edge.
   always @(posedge clock) begin
      if (fetch_en) cur <= lookup(p_ctr);
   end

   task automatic push(input logic [4:0] s, input logic [63:0] pc, input logic [2:0] st,
                       input logic b, input logic d);
      exp_t e;
      e.strb = s; e.pc = pc; e.stat = st; e.busy = b; e.done = d;
      exp_q.push_back(e);
   endtask

   // Walk the program instruction by instruction and list each cycle's outputs.
   task automatic build_trace(output int stop_idx);
      logic [63:0] pc;
      logic [2:0]  fin;
      ins_t        i;
      pc  = 64'd0;
      fin = 3'd1;
      exp_q.delete();
      for (int k = 0; k < 32; k++) begin
         if (pc >= 64'd1024) begin
            push(5'b00000, pc, 3'd1, 1'b1, 1'b0); fin = 3'd3; break;
         end
         i = lookup(pc);
         push(5'b10000, pc, 3'd1, 1'b1, 1'b0);
         if (i.bad || i.ierr || i.halt) begin
            push(5'b00000, pc, 3'd1, 1'b1, 1'b0);
            fin = i.bad ? 3'd3 : (i.ierr ? 3'd4 : 3'd2);
            break;
         end
         push(5'b01000, pc, 3'd1, 1'b1, 1'b0);
         push(5'b00100, pc, 3'd1, 1'b1, 1'b0);
         push(5'b00010, pc, 3'd1, 1'b1, 1'b0);
         if (i.derr) begin fin = 3'd3; break; end
         push(5'b00001, pc, 3'd1, 1'b1, 1'b0);
         push(5'b00000, pc, 3'd1, 1'b1, 1'b0);
         if (i.icode == 4'd8 || (i.icode == 4'd7 && i.cnd)) pc = i.vc;
         else if (i.icode == 4'd9) pc = i.vm;
         else pc = i.vp;
      end
      stop_idx = exp_q.size();
      for (int k = 0; k < 3; k++) push(5'b00000, pc, fin, 1'b0, 1'b1);
   endtask

   // Single compare process: one check per cycle against the trace model.
   always @(negedge clock) begin
      exp_t e;
      logic [4:0] s;
      if (chk_en && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         s = {fetch_en, decode_en, execute_en, memory_en, writeback_en};
         n_chk++;
         if (s !== e.strb || p_ctr !== e.pc || stat !== e.stat || busy !== e.busy || done !== e.done) begin
            n_fail++;
            $display("FAIL trace cyc%0d: got strb=%b pc=%h stat=%0d busy=%b done=%b, want strb=%b pc=%h stat=%0d busy=%b done=%b",
                     cyc, s, p_ctr, stat, busy, done, e.strb, e.pc, e.stat, e.busy, e.done);
         end
         cyc++;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_strb"}, {59'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en}, 64'd0);
      check({name, "_pc"}, p_ctr, 64'd0);
      check({name, "_ctl"}, {59'd0, stat, busy, done}, {59'd0, 3'd1, 1'b0, 1'b0});
`ifdef SEQ_PERF_COUNTERS_EN
      check({name, "_cnt"}, cycle_cnt | instr_cnt, 64'd0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_reset_vals("reset");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic run_prog(input string name, input int want_stop, input logic [63:0] want_pc,
                           input logic [2:0] want_stat);
      int stop_idx;
      int t;
      do_reset();
      build_trace(stop_idx);
      check({name, "_model_stop"}, 64'(stop_idx), 64'(want_stop));
      cyc = 0;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start  = 1'b0;
      chk_en = 1'b1;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clock);
         t++;
      end
      #1;
      chk_en = 1'b0;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d trace entries left, want 0", name, exp_q.size());
      end
      check({name, "_final_pc"}, p_ctr, want_pc);
      check({name, "_final_stat"}, {61'd0, stat}, {61'd0, want_stat});
      check({name, "_done"}, {63'd0, done}, 64'd1);
   endtask

   localparam logic [63:0] Z = 64'd0;

   initial begin
      int t;
      // nop; halt
      prog.delete();
      prog[0] = mk(4'd1, Z, 64'd1, Z, 0, 0, 0, 0, 0);
      prog[1] = mk(4'd0, Z, 64'd2, Z, 1, 0, 0, 0, 0);
      run_prog("nop_halt", 8, 64'd1, 3'd2);

      // jXX taken
      prog.delete();
      prog[0]     = mk(4'd7, 64'h20, 64'd9, Z, 0, 0, 0, 1, 0);
      prog[64'h20] = mk(4'd0, Z, 64'h21, Z, 1, 0, 0, 0, 0);
      run_prog("jxx_taken", 8, 64'h20, 3'd2);

      // jXX not taken
      prog.delete();
      prog[0] = mk(4'd7, 64'h20, 64'd9, Z, 0, 0, 0, 0, 0);
      prog[9] = mk(4'd0, Z, 64'd10, Z, 1, 0, 0, 0, 0);
      run_prog("jxx_not", 8, 64'd9, 3'd2);

      // call then ret (cnd asserted on call must not matter)
      prog.delete();
      prog[0]      = mk(4'd8, 64'h40, 64'd9, Z, 0, 0, 0, 0, 0);
      prog[64'h40] = mk(4'd9, 64'h77, 64'h41, 64'h13, 0, 0, 0, 1, 0);
      prog[64'h13] = mk(4'd0, Z, 64'h14, Z, 1, 0, 0, 0, 0);
      run_prog("call_ret", 14, 64'h13, 3'd2);

      // invalid instruction after a nop
      prog.delete();
      prog[0] = mk(4'd1, Z, 64'd1, Z, 0, 0, 0, 0, 0);
      prog[1] = mk(4'd15, Z, 64'd2, Z, 0, 0, 1, 0, 0);
      run_prog("ins_err", 8, 64'd1, 3'd4);

      // data memory fault
      prog.delete();
      prog[0] = mk(4'd5, 64'h10, 64'd10, Z, 0, 0, 0, 0, 1);
      run_prog("dmem_err", 4, 64'd0, 3'd3);

      // jump to MEM_BYTES
      prog.delete();
      prog[0] = mk(4'd7, 64'd1024, 64'd9, Z, 0, 0, 0, 1, 0);
      run_prog("pc_oob", 7, 64'd1024, 3'd3);

      // bad_mem outranks in_error and halt
      prog.delete();
      prog[0] = mk(4'd0, Z, 64'd1, Z, 1, 1, 1, 0, 0);
      run_prog("bad_prio", 2, 64'd0, 3'd3);

      // in_error outranks halt
      prog.delete();
      prog[0] = mk(4'd0, Z, 64'd1, Z, 1, 0, 1, 0, 0);
      run_prog("ins_prio", 2, 64'd0, 3'd4);

      // two nops then halt
      prog.delete();
      prog[0] = mk(4'd1, Z, 64'd1, Z, 0, 0, 0, 0, 0);
      prog[1] = mk(4'd1, Z, 64'd2, Z, 0, 0, 0, 0, 0);
      prog[2] = mk(4'd0, Z, 64'd3, Z, 1, 0, 0, 0, 0);
      run_prog("nop2", 14, 64'd2, 3'd2);
`ifdef SEQ_PERF_COUNTERS_EN
      check("instr_cnt", instr_cnt, 64'd2);
      check("cycle_cnt", cycle_cnt, 64'd14);
`endif

      // reset while EXECUTE is active, on a jump that would redirect the PC
      prog.delete();
      prog[0]      = mk(4'd7, 64'h30, 64'd9, Z, 0, 0, 0, 1, 0);
      prog[64'h30] = mk(4'd0, Z, 64'h31, Z, 1, 0, 0, 0, 0);
      do_reset();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      t = 0;
      while (!execute_en && t < 20) begin
         @(negedge clock);
         t++;
      end
      check("exec_reached", {63'd0, execute_en}, 64'd1);
      reset_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      @(negedge clock);
      reset_n = 1'b1;
      run_prog("after_reset", 8, 64'h30, 3'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
